// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned divider using repeated subtraction.
//
// After start is sampled in IDLE, the dividend and then the divisor arrive
// on data_in on consecutive cycles. The quotient counts how many times the
// divisor can be subtracted from the running remainder.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        level request to begin, sampled in IDLE
//   data_in      shared operand bus: dividend (LDA edge), divisor (LDB edge)
//   quotient     registered quotient, valid while done=1
//   remainder    registered remainder, valid while done=1
//   busy         high in LDA, LDB, SUB
//   done         high in DONE
//   div_by_zero  set when a zero divisor is loaded, cleared on the next LDA
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// LDA   | capture dividend into remainder register, clear quotient
// LDB   | capture divisor; zero divisor goes straight to DONE
// SUB   | subtract divisor from remainder while remainder >= divisor
// DONE  | results held; leave when start drops
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] b_reg;
  logic             r_ge_b;

  assign r_ge_b = (remainder >= b_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LDA : IDLE;
      LDA:     state_nxt = LDB;
      LDB:     state_nxt = (data_in == '0) ? DONE : SUB;
      SUB:     state_nxt = r_ge_b ? SUB : DONE;
      DONE:    state_nxt = start ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LDA, LDB, SUB: busy = 1'b1;
      DONE:          done = 1'b1;
      default:       ;
    endcase
  end

  // Datapath. The remainder register doubles as the dividend holder; the
  // quotient cannot wrap because it never exceeds the dividend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      b_reg       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        LDA: begin
          remainder   <= data_in;
          quotient    <= '0;
          div_by_zero <= 1'b0;
        end
        LDB: begin
          b_reg <= data_in;
          if (data_in == '0) begin
            // Saturated quotient marks the result as meaningless.
            div_by_zero <= 1'b1;
            quotient    <= '1;
          end
        end
        SUB: begin
          if (r_ge_b) begin
            remainder <= remainder - b_reg;
            quotient  <= quotient + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dbz;
    int          lat;
    int          s_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each completed division against the queued expectation.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending operation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("latency", cyc - e.s_cyc + 1, e.lat);
        chk("busy_in_done", busy, 0);
      end
    end
    done_q <= done;
  end

  // Reference model: plain integer division, latency counted with the
  // start-sampling edge as edge 1.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int s);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF; e.r = a; e.dbz = 1; e.lat = 3;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = 3 + int'(a / b) + 1;
    end
    e.s_cyc = s;
    return e;
  endfunction

  task automatic do_div(input int unsigned a, input int unsigned b, input bit hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    start   = 1'b1;
    data_in = W'($urandom);
    @(negedge clk);
    e = model(a, b, cyc);
    exp_q.push_back(e);
    chk("busy_after_start", busy, 1);
    start   = hold;
    data_in = W'(a);
    @(negedge clk);
    data_in = W'(b);
    @(negedge clk);
    data_in = W'($urandom);
    seen = 1'b0;
    for (int i = 0; i < e.lat + 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done=0 required done within %0d edges for %0d/%0d", e.lat, a, b);
      exp_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else if (!hold) begin
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    do_div(17, 5, 0);
    do_div(20, 5, 0);
    do_div(4, 5, 0);
    do_div(9, 0, 0);
    chk("idle_hold_quotient", quotient, 16'hFFFF);
    chk("idle_hold_remainder", remainder, 9);
    chk("idle_done", done, 0);

    // Level-high start must not retrigger from DONE.
    do_div(17, 5, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_done", done, 1);
      chk("hold_quotient", quotient, 3);
      chk("hold_remainder", remainder, 2);
    end
    start = 1'b0;
    do_div(0, 7, 0);

    // Abandon a long division mid-SUB.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'hFFFF;
    @(negedge clk);
    data_in = 16'd1;
    @(negedge clk);
    repeat (100) @(negedge clk);
    chk("mid_quotient", quotient, 100);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    do_div(100, 7, 0);

    for (int i = 0; i < 24; i++) begin
      int unsigned a;
      int unsigned b;
      a = $urandom_range(0, 65535);
      if (i % 6 == 5) b = 0;
      else b = $urandom_range(64, 65535);
      do_div(a, b, 0);
    end
    do_div(65535, 65535, 0);
    do_div(65535, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
